// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 9-bit instruction word: formats, error codes,
// loader states and the opcode constants the decoder also imports.
package isa_pkg;

  typedef enum logic [2:0] {
    FMT_RR3 = 3'd0,
    FMT_RR2 = 3'd1,
    FMT_BR  = 3'd2,
    FMT_R1  = 3'd3,
    FMT_MEM = 3'd4
  } fmt_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FIELD = 2'd1,
    OVF   = 2'd2,
    FMT   = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam logic [4:0] OPC_JMP      = 5'b10010;
  localparam logic [4:0] OPC_MEMI     = 5'b11000;
  localparam logic [7:0] MEM_IMM_BASE = 8'd64;
  localparam logic [7:0] MEM_IMM_TOP  = 8'd79;
  // Branch opcodes are 1000x plus JMP; single-register opcodes are 101xx.
  localparam logic [3:0] BR_PREFIX    = 4'b1000;
  localparam logic [2:0] R1_PREFIX    = 3'b101;

endpackage

// File: rtl/instr_packer.sv
// Combinational packer: turns one field-level micro-instruction into a 9-bit
// word and reports the highest-priority encoding error (FMT over FIELD).
module instr_packer
  import isa_pkg::*;
(
  input  logic [2:0] fmt,
  input  logic [4:0] opc,
  input  logic [2:0] ra,
  input  logic [2:0] rb,
  input  logic [7:0] imm,
  output logic [8:0] instr,
  output err_e       err_code
);

  logic [3:0] mem_off_s;

  // Only the low nibble of the data-address offset is encoded.
  assign mem_off_s = imm[3:0] - MEM_IMM_BASE[3:0];

  // Format-dependent packing and range checks.
  always_comb begin
    instr    = 9'h000;
    err_code = NONE;
    case (fmt)
      FMT_RR3: begin
        instr    = {2'b00, opc[0], ra, rb};
        err_code = NONE;
      end
      FMT_RR2: begin
        instr = {2'b01, opc[2:0], ra[1:0], rb[1:0]};
        if (ra[2] || rb[2]) err_code = FIELD;
        else                err_code = NONE;
      end
      FMT_BR: begin
        instr = {opc, imm[3:0]};
        if (!((opc[4:1] == BR_PREFIX) || (opc == OPC_JMP))) err_code = FMT;
        else if (imm > 8'd15)                                 err_code = FIELD;
        else                                                  err_code = NONE;
      end
      FMT_R1: begin
        instr = {opc, 1'b0, ra};
        if (opc[4:2] != R1_PREFIX) err_code = FMT;
        else                       err_code = NONE;
      end
      FMT_MEM: begin
        instr = {OPC_MEMI, mem_off_s};
        if (opc != OPC_MEMI)                                  err_code = FMT;
        else if ((imm < MEM_IMM_BASE) || (imm > MEM_IMM_TOP)) err_code = FIELD;
        else                                                  err_code = NONE;
      end
      default: begin
        instr    = 9'h000;
        err_code = FMT;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts micro-instruction beats, packs them, and writes the
// words sequentially into instruction memory, stopping on the first error.
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_fmt,
  input  logic [4:0]    in_opc,
  input  logic [2:0]    in_ra,
  input  logic [2:0]    in_rb,
  input  logic [7:0]    in_imm,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [8:0]    imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] err_addr,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_r,    state_n;
  logic [AW-1:0] wr_ptr_r,   wr_ptr_n;
  logic [AW:0]   count_r,    count_n;
  err_e          err_code_r, err_code_n;
  logic [AW-1:0] err_addr_r, err_addr_n;
  logic          we_r,       we_n;
  logic [AW-1:0] addr_r,     addr_n;
  logic [8:0]    wdata_r,    wdata_n;
  logic [8:0]    pk_instr_s;
  err_e          pk_err_s;

  instr_packer u_packer (
    .fmt      (in_fmt),
    .opc      (in_opc),
    .ra       (in_ra),
    .rb       (in_rb),
    .imm      (in_imm),
    .instr    (pk_instr_s),
    .err_code (pk_err_s)
  );

  // Next-state, pointer, error and write-port decisions.
  always_comb begin
    state_n    = state_r;
    wr_ptr_n   = wr_ptr_r;
    count_n    = count_r;
    err_code_n = err_code_r;
    err_addr_n = err_addr_r;
    we_n       = 1'b0;
    addr_n     = addr_r;
    wdata_n    = wdata_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n    = S_RUN;
          wr_ptr_n   = base_addr;
          count_n    = '0;
          err_code_n = NONE;
        end else begin
          state_n    = state_r;
        end
      end
      S_RUN: begin
        if (in_valid && (pk_err_s != NONE)) begin
          state_n    = S_ERR;
          err_code_n = pk_err_s;
          err_addr_n = wr_ptr_r;
        end else if (in_valid) begin
          we_n    = 1'b1;
          addr_n  = wr_ptr_r;
          wdata_n = pk_instr_s;
          count_n = count_r + (AW+1)'(1);
          // The pointer parks at the top address instead of wrapping.
          if (wr_ptr_r != LAST_ADDR) wr_ptr_n = wr_ptr_r + AW'(1);
          else                       wr_ptr_n = wr_ptr_r;
          if (in_last) begin
            state_n = S_DONE;
          end else if (wr_ptr_r == LAST_ADDR) begin
            state_n    = S_ERR;
            err_code_n = OVF;
            err_addr_n = wr_ptr_r;
          end else begin
            state_n = S_RUN;
          end
        end else begin
          state_n = S_RUN;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; reset clears the write strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      err_code_r <= NONE;
      err_addr_r <= '0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 9'h000;
    end else begin
      state_r    <= state_n;
      wr_ptr_r   <= wr_ptr_n;
      count_r    <= count_n;
      err_code_r <= err_code_n;
      err_addr_r <= err_addr_n;
      we_r       <= we_n;
      addr_r     <= addr_n;
      wdata_r    <= wdata_n;
    end
  end

  assign in_ready   = (state_r == S_RUN);
  assign busy       = (state_r == S_RUN);
  assign done       = (state_r == S_DONE);
  assign err        = (state_r == S_ERR);
  assign err_code   = err_code_r;
  assign err_addr   = err_addr_r;
  assign count      = count_r;
  assign imem_we    = we_r;
  assign imem_addr  = addr_r;
  assign imem_wdata = wdata_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader: a 256-deep instance
// for encoding/error/restart/reset and a 4-deep instance for overflow.
module tb_instr_encoder_loader;

  logic       clk, rst_n;
  logic       start, in_valid, in_last;
  logic [7:0] base_addr;
  logic [2:0] in_fmt, in_ra, in_rb;
  logic [4:0] in_opc;
  logic [7:0] in_imm;
  logic       in_ready, imem_we, busy, done, err;
  logic [7:0] imem_addr, err_addr;
  logic [8:0] imem_wdata, count;
  logic [1:0] err_code;

  logic       start4, valid4, ready4, we4, busy4, done4, err4;
  logic [1:0] base4, addr4, eaddr4, code4;
  logic [8:0] wdata4;
  logic [2:0] count4;

  int checks = 0;
  int fails  = 0;

  instr_encoder_loader #(.DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opc(in_opc),
    .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .err_addr(err_addr), .count(count)
  );

  instr_encoder_loader #(.DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .base_addr(base4),
    .in_valid(valid4), .in_ready(ready4), .in_fmt(in_fmt), .in_opc(in_opc),
    .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4),
    .busy(busy4), .done(done4), .err(err4), .err_code(code4),
    .err_addr(eaddr4), .count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_beat(input logic [2:0] f, input logic [4:0] o, input logic [2:0] a,
                          input logic [2:0] b, input logic [7:0] i, input logic l);
    in_fmt = f; in_opc = o; in_ra = a; in_rb = b; in_imm = i; in_last = l;
  endtask

  task automatic start_load(input logic [7:0] b);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset_we got=%0h exp=0", imem_we); end
    checks++; if ({busy, done, err, in_ready} !== 4'b0000) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, err, in_ready}); end
    checks++; if ({err_code, err_addr, count, imem_addr, imem_wdata} !== 36'h0) begin fails++; $display("FAIL reset_regs got=%0h exp=0", {err_code, err_addr, count, imem_addr, imem_wdata}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    set_beat(3'd0, 5'd1, 3'd5, 3'd2, 8'd0, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if ({imem_we, in_ready, busy} !== 3'b000) begin fails++; $display("FAIL idle_ignore got=%b exp=000", {imem_we, in_ready, busy}); end
    in_valid = 1'b0;
  endtask

  task automatic test_rr3();
    start_load(8'd0);
    checks++; if ({busy, in_ready} !== 2'b11) begin fails++; $display("FAIL rr3_run got=%b exp=11", {busy, in_ready}); end
    set_beat(3'd0, 5'd1, 3'd5, 3'd2, 8'd0, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'd0, 9'h06A}) begin fails++; $display("FAIL rr3_write got=%0h/%0h/%0h exp=1/0/6a", imem_we, imem_addr, imem_wdata); end
    checks++; if ({done, busy, count} !== {1'b1, 1'b0, 9'd1}) begin fails++; $display("FAIL rr3_done got=%b/%b/%0d exp=1/0/1", done, busy, count); end
    @(negedge clk);
    checks++; if (imem_we !== 1'b0) begin fails++; $display("FAIL rr3_single got=%0h exp=0", imem_we); end
  endtask

  task automatic test_back_to_back();
    start_load(8'd10);
    set_beat(3'd4, 5'b11000, 3'd0, 3'd0, 8'd70, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'd10, 9'h186}) begin fails++; $display("FAIL b2b_mem got=%0h/%0h/%0h exp=1/a/186", imem_we, imem_addr, imem_wdata); end
    set_beat(3'd2, 5'b10010, 3'd0, 3'd0, 8'd9, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'd11, 9'h129}) begin fails++; $display("FAIL b2b_br got=%0h/%0h/%0h exp=1/b/129", imem_we, imem_addr, imem_wdata); end
    checks++; if ({done, count} !== {1'b1, 9'd2}) begin fails++; $display("FAIL b2b_done got=%b/%0d exp=1/2", done, count); end
  endtask

  task automatic test_field_error();
    start_load(8'd3);
    set_beat(3'd0, 5'd0, 3'd1, 3'd1, 8'd0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'd3, 9'h009}) begin fails++; $display("FAIL field_good got=%0h/%0h/%0h exp=1/3/9", imem_we, imem_addr, imem_wdata); end
    set_beat(3'd1, 5'd0, 3'd4, 3'd0, 8'd0, 1'b0);
    @(negedge clk);
    checks++; if ({imem_we, err, err_code, err_addr} !== {1'b0, 1'b1, 2'd1, 8'd4}) begin fails++; $display("FAIL field_err got=%0h/%0h/%0h/%0h exp=0/1/1/4", imem_we, err, err_code, err_addr); end
    checks++; if ({in_ready, count} !== {1'b0, 9'd1}) begin fails++; $display("FAIL field_stop got=%0h/%0d exp=0/1", in_ready, count); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({imem_we, err} !== 2'b01) begin fails++; $display("FAIL field_nowrite got=%b exp=01", {imem_we, err}); end
  endtask

  task automatic test_formats();
    logic [2:0] f   [4] = '{3'd1, 3'd3, 3'd4, 3'd2};
    logic [4:0] o   [4] = '{5'b00101, 5'b10110, 5'b11000, 5'b10001};
    logic [2:0] a   [4] = '{3'd2, 3'd3, 3'd0, 3'd0};
    logic [2:0] b   [4] = '{3'd3, 3'd0, 3'd0, 3'd0};
    logic [7:0] im  [4] = '{8'd0, 8'd0, 8'd79, 8'd15};
    logic [8:0] exp [4] = '{9'h0DB, 9'h163, 9'h18F, 9'h11F};
    start_load(8'd30);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_beat(f[k], o[k], a[k], b[k], im[k], 1'b0);
      @(negedge clk);
      checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'(30 + k), exp[k]}) begin fails++; $display("FAIL fmt_enc%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, imem_we, imem_addr, imem_wdata, 30 + k, exp[k]); end
    end
    set_beat(3'd4, 5'b11000, 3'd0, 3'd0, 8'd80, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({imem_we, err_code, err_addr, count} !== {1'b0, 2'd1, 8'd34, 9'd4}) begin fails++; $display("FAIL mem_hi got=%0h/%0h/%0h/%0d exp=0/1/22/4", imem_we, err_code, err_addr, count); end
  endtask

  task automatic test_restart();
    logic [2:0] f  [4] = '{3'd2, 3'd5, 3'd3, 3'd4};
    logic [4:0] o  [4] = '{5'b00001, 5'b10010, 5'b11000, 5'b11000};
    logic [7:0] im [4] = '{8'd200, 8'd0, 8'd0, 8'd63};
    logic [1:0] ec [4] = '{2'd3, 2'd3, 2'd3, 2'd1};
    start_load(8'd40);
    checks++; if ({busy, err, done, err_code, count} !== {3'b100, 2'd0, 9'd0}) begin fails++; $display("FAIL restart_clear got=%b/%b/%b/%0h/%0d exp=1/0/0/0/0", busy, err, done, err_code, count); end
    start_load(8'd60);
    set_beat(3'd0, 5'd0, 3'd7, 3'd7, 8'd0, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({imem_we, imem_addr, imem_wdata, done} !== {1'b1, 8'd40, 9'h03F, 1'b1}) begin fails++; $display("FAIL start_in_run got=%0h/%0h/%0h/%0h exp=1/28/3f/1", imem_we, imem_addr, imem_wdata, done); end
    for (int k = 0; k < 4; k++) begin
      start_load(8'(50 + 2 * k));
      set_beat(f[k], o[k], 3'd0, 3'd0, im[k], 1'b1);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if ({imem_we, err, err_code, err_addr} !== {2'b01, ec[k], 8'(50 + 2 * k)}) begin fails++; $display("FAIL err_vec%0d got=%0h/%0h/%0h/%0h exp=0/1/%0h/%0h", k, imem_we, err, err_code, err_addr, ec[k], 50 + 2 * k); end
    end
  endtask

  task automatic test_overflow();
    start4 = 1'b1; base4 = 2'd2;
    @(negedge clk);
    start4 = 1'b0;
    set_beat(3'd0, 5'd1, 3'd1, 3'd2, 8'd0, 1'b0);
    valid4 = 1'b1;
    @(negedge clk);
    checks++; if ({we4, addr4, wdata4} !== {1'b1, 2'd2, 9'h04A}) begin fails++; $display("FAIL ovf_w2 got=%0h/%0h/%0h exp=1/2/4a", we4, addr4, wdata4); end
    @(negedge clk);
    checks++; if ({we4, addr4} !== {1'b1, 2'd3}) begin fails++; $display("FAIL ovf_w3 got=%0h/%0h exp=1/3", we4, addr4); end
    checks++; if ({err4, code4, eaddr4, count4, ready4} !== {1'b1, 2'd2, 2'd3, 3'd2, 1'b0}) begin fails++; $display("FAIL ovf_err got=%0h/%0h/%0h/%0d/%0h exp=1/2/3/2/0", err4, code4, eaddr4, count4, ready4); end
    @(negedge clk);
    valid4 = 1'b0;
    checks++; if (we4 !== 1'b0) begin fails++; $display("FAIL ovf_third got=%0h exp=0", we4); end
    start4 = 1'b1; base4 = 2'd3;
    @(negedge clk);
    start4 = 1'b0;
    set_beat(3'd0, 5'd0, 3'd0, 3'd1, 8'd0, 1'b1);
    valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    checks++; if ({we4, addr4, done4, err4, count4} !== {1'b1, 2'd3, 2'b10, 3'd1}) begin fails++; $display("FAIL top_last got=%0h/%0h/%0h/%0h/%0d exp=1/3/1/0/1", we4, addr4, done4, err4, count4); end
  endtask

  task automatic test_reset_mid();
    start_load(8'd0);
    set_beat(3'd0, 5'd1, 3'd1, 3'd1, 8'd0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    checks++; if (imem_we !== 1'b1) begin fails++; $display("FAIL mid_pre got=%0h exp=1", imem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (imem_we !== 1'b0) begin fails++; $display("FAIL mid_we got=%0h exp=0", imem_we); end
    checks++; if ({busy, done, err, in_ready, err_code, count, imem_addr, imem_wdata} !== 32'h0) begin fails++; $display("FAIL mid_outs got=%0h exp=0", {busy, done, err, in_ready, err_code, count, imem_addr, imem_wdata}); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({imem_we, busy, done, err} !== 4'b0000) begin fails++; $display("FAIL mid_idle got=%b exp=0000", {imem_we, busy, done, err}); end
  endtask

  initial begin
    start = 1'b0; base_addr = 8'd0; in_valid = 1'b0;
    start4 = 1'b0; base4 = 2'd0; valid4 = 1'b0;
    set_beat(3'd0, 5'd0, 3'd0, 3'd0, 8'd0, 1'b0);
    test_reset();
    test_rr3();
    test_back_to_back();
    test_field_error();
    test_formats();
    test_restart();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
